// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, FSM state types and a saturating counter helper for the Ethernet framing layer.
package eth_pkg;
    localparam int ETH_HDR_BYTES = 14;
    localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

    typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_PAYLOAD, TX_PAD, TX_DISCARD} tx_state_t;
    typedef enum logic [1:0] {RX_HDR, RX_FWD, RX_DROP} rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/eth_rx_filter.sv
// eth_rx_filter: strips the Ethernet header, filters on destination and EtherType, counts good and dropped frames.
module eth_rx_filter
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
    parameter logic [15:0] ETH_TYPE = ETH_TYPE_IPV4,
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        promisc_en,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_valid,
    input  logic        mac_rx_last,
    output logic        mac_rx_ready,
    output logic [7:0]  rx_out_data,
    output logic        rx_out_valid,
    output logic        rx_out_last,
    input  logic        rx_out_ready,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_drop_cnt
);
    rx_state_t state, state_nxt;
    logic [3:0] idx;
    logic [103:0] hdr_q;
    logic [111:0] hdr_full;
    logic rx_hs, hdr_done, match;

    // the match is taken on the incoming 14th byte, so the header is seen as stored bytes plus the live one
    assign hdr_full = {hdr_q, mac_rx_data};
    assign rx_hs = mac_rx_valid && mac_rx_ready;
    assign hdr_done = idx == 4'(ETH_HDR_BYTES - 1);
    assign match = (hdr_full[111:64] == LOCAL_MAC || (ACCEPT_BCAST && hdr_full[111:64] == ETH_BCAST) || promisc_en)
                   && hdr_full[15:0] == ETH_TYPE;

    always_comb begin
        state_nxt = state;
        mac_rx_ready = 1'b1;
        rx_out_valid = 1'b0;
        rx_out_data = 8'h00;
        rx_out_last = 1'b0;
        case (state)
            RX_HDR: if (rx_hs && !mac_rx_last && hdr_done) state_nxt = match ? RX_FWD : RX_DROP;
            RX_FWD: begin
                mac_rx_ready = rx_out_ready;
                rx_out_valid = mac_rx_valid;
                rx_out_data = mac_rx_data;
                rx_out_last = mac_rx_last;
                if (rx_hs && mac_rx_last) state_nxt = RX_HDR;
            end
            RX_DROP: if (rx_hs && mac_rx_last) state_nxt = RX_HDR;
            default: state_nxt = RX_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_HDR;
            idx <= '0;
            hdr_q <= '0;
            rx_good_cnt <= '0;
            rx_drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == RX_HDR && rx_hs) begin
                hdr_q <= hdr_full[103:0];
                idx <= (mac_rx_last || hdr_done) ? 4'd0 : idx + 4'd1;
            end
            if (state == RX_FWD && rx_hs && mac_rx_last) rx_good_cnt <= sat_inc(rx_good_cnt);
            if (state != RX_FWD && rx_hs && mac_rx_last) rx_drop_cnt <= sat_inc(rx_drop_cnt);
        end
    end
endmodule

// File: rtl/eth_frame_adapter.sv
// eth_frame_adapter: byte-stream Ethernet framing; TX adds header, pads and truncates, RX filters via eth_rx_filter.
module eth_frame_adapter
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
    parameter logic [47:0] REMOTE_MAC = 48'h000A35000002,
    parameter logic [15:0] ETH_TYPE = ETH_TYPE_IPV4,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        promisc_en,
    input  logic [7:0]  tx_in_data,
    input  logic        tx_in_valid,
    input  logic        tx_in_last,
    output logic        tx_in_ready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_last,
    input  logic        mac_tx_ready,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_valid,
    input  logic        mac_rx_last,
    output logic        mac_rx_ready,
    output logic [7:0]  rx_out_data,
    output logic        rx_out_valid,
    output logic        rx_out_last,
    input  logic        rx_out_ready,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_drop_cnt,
    output logic [15:0] tx_trunc_cnt
);
    localparam logic [111:0] HDR_BITS = {REMOTE_MAC, LOCAL_MAC, ETH_TYPE};

    tx_state_t state, state_nxt;
    logic [3:0] hdr_idx;
    logic [10:0] n;
    logic tx_hs, in_hs, at_max, short_frame, pad_done;

    assign tx_hs = mac_tx_valid && mac_tx_ready;
    assign in_hs = tx_in_valid && tx_in_ready;
    assign at_max = n == 11'(MAX_PAYLOAD - 1);
    assign short_frame = int'(n) + 1 < MIN_PAYLOAD;
    assign pad_done = n == 11'(MIN_PAYLOAD - 1);

    always_comb begin
        state_nxt = state;
        tx_in_ready = 1'b0;
        mac_tx_valid = 1'b0;
        mac_tx_data = 8'h00;
        mac_tx_last = 1'b0;
        case (state)
            TX_IDLE: if (tx_in_valid) state_nxt = TX_HDR;
            TX_HDR: begin
                mac_tx_valid = 1'b1;
                mac_tx_data = HDR_BITS[{4'd13 - hdr_idx, 3'b000} +: 8];
                if (mac_tx_ready && hdr_idx == 4'(ETH_HDR_BYTES - 1)) state_nxt = TX_PAYLOAD;
            end
            TX_PAYLOAD: begin
                tx_in_ready = mac_tx_ready;
                mac_tx_valid = tx_in_valid;
                mac_tx_data = tx_in_data;
                mac_tx_last = (tx_in_last && !short_frame) || at_max;
                if (in_hs) state_nxt = tx_in_last ? (short_frame ? TX_PAD : TX_IDLE) : (at_max ? TX_DISCARD : TX_PAYLOAD);
            end
            TX_PAD: begin
                mac_tx_valid = 1'b1;
                mac_tx_last = pad_done;
                if (mac_tx_ready && pad_done) state_nxt = TX_IDLE;
            end
            TX_DISCARD: begin
                tx_in_ready = 1'b1;
                if (tx_in_valid && tx_in_last) state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // n counts payload bytes and keeps counting through padding, so one counter decides both pad end and truncation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
            hdr_idx <= '0;
            n <= '0;
            tx_trunc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == TX_IDLE) begin
                hdr_idx <= '0;
                n <= '0;
            end
            if (state == TX_HDR && tx_hs) hdr_idx <= hdr_idx + 4'd1;
            if ((state == TX_PAYLOAD && in_hs) || (state == TX_PAD && tx_hs)) n <= n + 11'd1;
            if (state == TX_PAYLOAD && in_hs && at_max && !tx_in_last) tx_trunc_cnt <= sat_inc(tx_trunc_cnt);
        end
    end

    eth_rx_filter #(
        .LOCAL_MAC   (LOCAL_MAC),
        .ETH_TYPE    (ETH_TYPE),
        .ACCEPT_BCAST(ACCEPT_BCAST)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .promisc_en  (promisc_en),
        .mac_rx_data (mac_rx_data),
        .mac_rx_valid(mac_rx_valid),
        .mac_rx_last (mac_rx_last),
        .mac_rx_ready(mac_rx_ready),
        .rx_out_data (rx_out_data),
        .rx_out_valid(rx_out_valid),
        .rx_out_last (rx_out_last),
        .rx_out_ready(rx_out_ready),
        .rx_good_cnt (rx_good_cnt),
        .rx_drop_cnt (rx_drop_cnt)
    );
endmodule

// File: tb/tb_eth_frame_adapter.sv
// tb_eth_frame_adapter: directed frames on TX and RX checked byte-by-byte against a queue-based frame model.
module tb_eth_frame_adapter;
    import eth_pkg::*;

    localparam logic [47:0] LOCAL = 48'h000A35000001;
    localparam logic [47:0] REMOTE = 48'h000A35000002;
    localparam logic [15:0] TYPE = 16'h0800;
    localparam int MINP = 46;
    localparam int MAXP = 1500;
    localparam int WAIT_MAX = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic promisc_en = 1'b0;
    logic [7:0] tx_in_data = 8'h00;
    logic tx_in_valid = 1'b0;
    logic tx_in_last = 1'b0;
    logic tx_in_ready;
    logic [7:0] mac_tx_data;
    logic mac_tx_valid;
    logic mac_tx_last;
    logic mac_tx_ready = 1'b1;
    logic [7:0] mac_rx_data = 8'h00;
    logic mac_rx_valid = 1'b0;
    logic mac_rx_last = 1'b0;
    logic mac_rx_ready;
    logic [7:0] rx_out_data;
    logic rx_out_valid;
    logic rx_out_last;
    logic rx_out_ready = 1'b1;
    logic [15:0] rx_good_cnt;
    logic [15:0] rx_drop_cnt;
    logic [15:0] tx_trunc_cnt;

    int checks = 0;
    int errors = 0;
    int m_good = 0;
    int m_drop = 0;
    int m_trunc = 0;
    bit chk_en = 1'b0;
    bit tx_bp = 1'b0;
    bit rx_bp = 1'b0;
    logic [8:0] txq[$];
    logic [8:0] rxq[$];
    logic [8:0] tx_obs[$];
    logic [8:0] rx_obs[$];

    eth_frame_adapter #(
        .LOCAL_MAC(LOCAL), .REMOTE_MAC(REMOTE), .ETH_TYPE(TYPE),
        .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP), .ACCEPT_BCAST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .promisc_en(promisc_en),
        .tx_in_data(tx_in_data), .tx_in_valid(tx_in_valid), .tx_in_last(tx_in_last), .tx_in_ready(tx_in_ready),
        .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_last(mac_tx_last), .mac_tx_ready(mac_tx_ready),
        .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid), .mac_rx_last(mac_rx_last), .mac_rx_ready(mac_rx_ready),
        .rx_out_data(rx_out_data), .rx_out_valid(rx_out_valid), .rx_out_last(rx_out_last), .rx_out_ready(rx_out_ready),
        .rx_good_cnt(rx_good_cnt), .rx_drop_cnt(rx_drop_cnt), .tx_trunc_cnt(tx_trunc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en && rst_n) begin
            if (mac_tx_valid && mac_tx_ready) begin
                tx_obs.push_back({mac_tx_last, mac_tx_data});
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected no byte", {mac_tx_last, mac_tx_data});
                end else chk("tx_byte", int'({mac_tx_last, mac_tx_data}), int'(txq.pop_front()));
            end
            if (rx_out_valid && rx_out_ready) begin
                rx_obs.push_back({rx_out_last, rx_out_data});
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %h expected no byte", {rx_out_last, rx_out_data});
                end else chk("rx_byte", int'({rx_out_last, rx_out_data}), int'(rxq.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        mac_tx_ready = tx_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        rx_out_ready = rx_bp ? !rx_out_ready : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tx_send(input int len);
        logic [7:0] f[$];
        logic [111:0] h;
        h = {REMOTE, LOCAL, TYPE};
        for (int i = 0; i < 14; i++) begin
            f.push_back(h[111:104]);
            h = h << 8;
        end
        for (int i = 0; i < len && i < MAXP; i++) f.push_back(8'(i + 1));
        while (f.size() < 14 + MINP) f.push_back(8'h00);
        foreach (f[i]) txq.push_back({i == f.size() - 1, f[i]});
        if (len > MAXP) m_trunc++;
        for (int i = 0; i < len; i++) begin
            int w;
            w = 0;
            tx_in_valid = 1'b1;
            tx_in_data = 8'(i + 1);
            tx_in_last = i == len - 1;
            @(negedge clk);
            while (!tx_in_ready && w < WAIT_MAX) begin
                w++;
                @(negedge clk);
            end
            if (!tx_in_ready) begin
                checks++;
                errors++;
                $display("FAIL tx_in_timeout: got no ready expected ready within %0d cycles", WAIT_MAX);
                break;
            end
            @(posedge clk);
            #1;
        end
        tx_in_valid = 1'b0;
        tx_in_last = 1'b0;
    endtask

    task automatic rx_send(input logic [47:0] dst, input logic [15:0] typ, input int npay, input logic [7:0] base, input int cut);
        logic [7:0] f[$];
        logic [111:0] h;
        h = {dst, REMOTE, typ};
        for (int i = 0; i < 14; i++) begin
            f.push_back(h[111:104]);
            h = h << 8;
        end
        for (int i = 0; i < npay; i++) f.push_back(base + 8'(i));
        if (cut > 0) while (f.size() > cut) void'(f.pop_back());
        if (f.size() <= 14) m_drop++;
        else if ((dst == LOCAL || dst == 48'hFFFF_FFFF_FFFF || promisc_en) && typ == TYPE) begin
            for (int i = 14; i < f.size(); i++) rxq.push_back({i == f.size() - 1, f[i]});
            m_good++;
        end else m_drop++;
        foreach (f[i]) begin
            int w;
            w = 0;
            mac_rx_valid = 1'b1;
            mac_rx_data = f[i];
            mac_rx_last = i == f.size() - 1;
            @(negedge clk);
            while (!mac_rx_ready && w < WAIT_MAX) begin
                w++;
                @(negedge clk);
            end
            if (!mac_rx_ready) begin
                checks++;
                errors++;
                $display("FAIL mac_rx_timeout: got no ready expected ready within %0d cycles", WAIT_MAX);
                break;
            end
            @(posedge clk);
            #1;
        end
        mac_rx_valid = 1'b0;
        mac_rx_last = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((txq.size() != 0 || rxq.size() != 0) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_tx_left", txq.size(), 0);
        chk("drain_rx_left", rxq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string t);
        chk({t, "_rx_good_cnt"}, int'(rx_good_cnt), m_good);
        chk({t, "_rx_drop_cnt"}, int'(rx_drop_cnt), m_drop);
        chk({t, "_tx_trunc_cnt"}, int'(tx_trunc_cnt), m_trunc);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_mac_tx_valid"}, int'(mac_tx_valid), 0);
        chk({t, "_mac_tx_last"}, int'(mac_tx_last), 0);
        chk({t, "_mac_tx_data"}, int'(mac_tx_data), 0);
        chk({t, "_tx_in_ready"}, int'(tx_in_ready), 0);
        chk({t, "_mac_rx_ready"}, int'(mac_rx_ready), 1);
        chk({t, "_rx_out_valid"}, int'(rx_out_valid), 0);
        chk({t, "_rx_out_last"}, int'(rx_out_last), 0);
        chk({t, "_rx_out_data"}, int'(rx_out_data), 0);
        chk({t, "_rx_good_cnt"}, int'(rx_good_cnt), 0);
        chk({t, "_rx_drop_cnt"}, int'(rx_drop_cnt), 0);
        chk({t, "_tx_trunc_cnt"}, int'(tx_trunc_cnt), 0);
    endtask

    initial begin
        int nl;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        tx_obs.delete();
        tx_send(10);
        drain();
        nl = 0;
        foreach (tx_obs[i]) nl += int'(tx_obs[i][8]);
        chk("tx10_len", tx_obs.size(), 60);
        chk("tx10_lasts", nl, 1);
        chk("tx10_b0", int'(tx_obs[0]), 'h000);
        chk("tx10_b2", int'(tx_obs[2]), 'h035);
        chk("tx10_b12", int'(tx_obs[12]), 'h008);
        chk("tx10_b14", int'(tx_obs[14]), 'h001);
        chk("tx10_b23", int'(tx_obs[23]), 'h00A);
        chk("tx10_b24", int'(tx_obs[24]), 'h000);
        chk("tx10_b59", int'(tx_obs[59]), 'h100);

        tx_obs.delete();
        tx_send(45);
        drain();
        chk("tx45_len", tx_obs.size(), 60);
        chk("tx45_b58", int'(tx_obs[58]), 'h02D);
        chk("tx45_b59", int'(tx_obs[59]), 'h100);

        tx_obs.delete();
        tx_send(46);
        drain();
        chk("tx46_len", tx_obs.size(), 60);
        chk("tx46_b59", int'(tx_obs[59]), 'h12E);

        tx_obs.delete();
        tx_send(1501);
        drain();
        chk("tx1501_len", tx_obs.size(), 1514);
        chk("tx1501_b1512", int'(tx_obs[1512]), 'h0DB);
        chk("tx1501_b1513", int'(tx_obs[1513]), 'h1DC);
        chk("tx1501_trunc", int'(tx_trunc_cnt), 1);
        chk_counters("tx");

        rx_bp = 1'b1;
        rx_obs.delete();
        rx_send(LOCAL, 16'h0800, 5, 8'hAA, 0);
        drain();
        chk("rx_local_len", rx_obs.size(), 5);
        chk("rx_local_b0", int'(rx_obs[0]), 'h0AA);
        chk("rx_local_b4", int'(rx_obs[4]), 'h1AE);
        chk("rx_local_good", int'(rx_good_cnt), 1);
        rx_bp = 1'b0;

        rx_obs.delete();
        rx_send(48'h000A35000009, 16'h0800, 4, 8'h10, 0);
        drain();
        chk("rx_other_len", rx_obs.size(), 0);
        chk("rx_other_drop", int'(rx_drop_cnt), 1);
        promisc_en = 1'b1;
        rx_send(48'h000A35000009, 16'h0800, 3, 8'h20, 0);
        drain();
        promisc_en = 1'b0;
        chk("rx_promisc_len", rx_obs.size(), 3);
        chk("rx_promisc_good", int'(rx_good_cnt), 2);

        rx_send(48'hFFFF_FFFF_FFFF, 16'h0806, 4, 8'h30, 0);
        rx_send(LOCAL, 16'h0800, 8, 8'h40, 10);
        rx_send(LOCAL, 16'h0800, 6, 8'h50, 0);
        rx_send(48'hFFFF_FFFF_FFFF, 16'h0800, 2, 8'h60, 0);
        drain();
        chk("rx_filter_drop", int'(rx_drop_cnt), 3);
        chk("rx_filter_good", int'(rx_good_cnt), 4);
        chk_counters("rx");

        tx_bp = 1'b1;
        rx_bp = 1'b1;
        fork
            tx_send(3);
            rx_send(LOCAL, 16'h0800, 20, 8'h80, 0);
        join
        drain();
        tx_bp = 1'b0;
        rx_bp = 1'b0;
        chk_counters("both");

        chk_en = 1'b0;
        tx_in_valid = 1'b1;
        tx_in_data = 8'h55;
        mac_rx_valid = 1'b1;
        mac_rx_data = 8'h77;
        repeat (5) @(posedge clk);
        #1;
        mac_rx_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        tx_in_valid = 1'b0;
        txq.delete();
        rxq.delete();
        m_good = 0;
        m_drop = 0;
        m_trunc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        tx_obs.delete();
        rx_obs.delete();
        fork
            tx_send(12);
            rx_send(LOCAL, 16'h0800, 4, 8'hC0, 0);
        join
        drain();
        chk("post_rst_tx_len", tx_obs.size(), 60);
        chk("post_rst_rx_len", rx_obs.size(), 4);
        chk("post_rst_good", int'(rx_good_cnt), 1);
        chk_counters("post_rst");

        chk("sat_inc_max", int'(sat_inc(16'hFFFF)), 'hFFFF);
        chk("sat_inc_mid", int'(sat_inc(16'h0005)), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
